// File: rtl/time_disp_pkg.sv
// time_disp_pkg: shared BCD display constants and FSM state type.
package time_disp_pkg;
    localparam int BCD_DIGITS = 4;
    localparam int DIGIT_W = 4;
    localparam int BCD_W = BCD_DIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one double-dabble iteration (per-nibble add-3, then shift in msb).
module bcd_dabble_step
    import time_disp_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    input  logic             msb,
    output logic [BCD_W-1:0] next
);
    logic [BCD_W-1:0] adj;
    always_comb begin
        adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++)
            adj[i*DIGIT_W +: DIGIT_W] = bcd[i*DIGIT_W +: DIGIT_W] >= 4'd5 ? bcd[i*DIGIT_W +: DIGIT_W] + 4'd3 : bcd[i*DIGIT_W +: DIGIT_W];
    end
    assign next = {adj[BCD_W-2:0], msb};
endmodule

// File: rtl/time_bcd_display.sv
// time_bcd_display: sequential binary-to-BCD conversion of the level timer, plus blink/flash cues.
// Define TIME_BCD_BLANK_LEADING_ZERO_EN to blank leading zero digits with BLANK_CODE.
module time_bcd_display
    import time_disp_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int WARN_THRESHOLD = 10,
    parameter int BLINK_HALF_PERIOD = 25_000_000,
    parameter int FLASH_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] counter,
    input  logic             time_out,
    output logic [BCD_W-1:0] digits,
    output logic             digits_valid,
    output logic             busy,
    output logic             warn_blink,
    output logic             timeout_flash
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int BLINK_W = $clog2(BLINK_HALF_PERIOD + 1);
    localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);
    state_t state, state_next;
    logic dirty, start, phase, blink_wrap;
    logic [WIDTH-1:0] last_val, shreg, disp_val;
    logic [BCD_W-1:0] bcd, bcd_next, shown;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0] to_sync;
    logic [FLASH_W-1:0] flash_cnt;
    logic [BLINK_W-1:0] blink_cnt;

    assign start = dirty || counter != last_val;
    assign busy = state == SHIFT;
    assign timeout_flash = flash_cnt != '0;
    assign blink_wrap = blink_cnt == BLINK_W'(BLINK_HALF_PERIOD - 1);
    assign warn_blink = phase && disp_val != '0 && disp_val <= WIDTH'(WARN_THRESHOLD);

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state == IDLE ? (start ? SHIFT : IDLE) :
                     state == SHIFT ? (bit_cnt == '0 ? DONE : SHIFT) : IDLE;
    end

    bcd_dabble_step u_step (.bcd(bcd), .msb(shreg[WIDTH-1]), .next(bcd_next));

    // Blank only zero digits with nothing but zeros above them; units always shown.
    always_comb begin
        shown = bcd;
`ifdef TIME_BCD_BLANK_LEADING_ZERO_EN
        for (int i = BCD_DIGITS - 1; i > 0; i--)
            if ((bcd >> (i * DIGIT_W)) == '0) shown[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
`endif
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            dirty <= 1'b1;
            last_val <= '0;
            shreg <= '0;
            bcd <= '0;
            bit_cnt <= '0;
            digits <= '0;
            digits_valid <= 1'b0;
            disp_val <= '0;
        end else begin
            digits_valid <= state == DONE;
            if (state == IDLE && start) begin
                shreg <= counter;
                last_val <= counter;
                bcd <= '0;
                dirty <= 1'b0;
                bit_cnt <= CNT_W'(WIDTH - 1);
            end
            if (state == SHIFT) begin
                bcd <= bcd_next;
                shreg <= shreg << 1;
                bit_cnt <= bit_cnt - CNT_W'(1);
            end
            if (state == DONE) begin
                digits <= shown;
                disp_val <= last_val;
            end
        end

    // to_sync[1:0] is the synchroniser; to_sync[2] delays it for edge detection.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            to_sync <= '0;
            flash_cnt <= '0;
            blink_cnt <= '0;
            phase <= 1'b0;
        end else begin
            to_sync <= {to_sync[1:0], time_out};
            flash_cnt <= to_sync[1] && !to_sync[2] ? FLASH_W'(FLASH_CYCLES) : flash_cnt - FLASH_W'(flash_cnt != '0);
            blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
            phase <= phase ^ blink_wrap;
        end
endmodule

// File: tb/tb_time_bcd_display.sv
// tb_time_bcd_display: table-driven and scoreboard checks of the BCD time display.
module tb_time_bcd_display;
    localparam int W = 12;
    localparam int BHP = 4;
    localparam int FC = 8;
    typedef struct {
        logic [W-1:0] val;
        logic [15:0]  raw;
        logic         warn;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic time_out = 1'b0;
    logic [W-1:0] counter = 12'd60;
    logic [15:0] digits;
    logic digits_valid, busy, warn_blink, timeout_flash;
    int total = 0;
    int bad = 0;
    int pulses = 0;
    logic [15:0] exp_q[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    time_bcd_display #(.WIDTH(W), .WARN_THRESHOLD(10), .BLINK_HALF_PERIOD(BHP), .FLASH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .counter(counter), .time_out(time_out), .digits(digits),
        .digits_valid(digits_valid), .busy(busy), .warn_blink(warn_blink), .timeout_flash(timeout_flash)
    );

    function automatic logic [15:0] shown(input logic [15:0] raw);
        logic [15:0] r;
        r = raw;
`ifdef TIME_BCD_BLANK_LEADING_ZERO_EN
        if (r[15:12] == 4'h0) begin
            r[15:12] = 4'hF;
            if (r[11:8] == 4'h0) begin
                r[11:8] = 4'hF;
                if (r[7:4] == 4'h0) r[7:4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (rst && digits_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got digits %0h expected no pulse", digits);
            end else check("scoreboard_digits", 32'(digits), 32'(exp_q.pop_front()));
        end

    task automatic wait_pulse(input int target, output int cyc);
        cyc = 0;
        while (pulses < target && cyc < 60) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("pulse_arrived", 32'(pulses >= target), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, 32'(digits), 0);
        check({tag, "_valid"}, 32'(digits_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_warn"}, 32'(warn_blink), 0);
        check({tag, "_flash"}, 32'(timeout_flash), 0);
    endtask

    initial begin
        int cyc, busy_n, hi, last_t, trans, c2;
        logic prev;
        vecs[0] = '{12'd4095, 16'h4095, 1'b0};
        vecs[1] = '{12'd0,    16'h0000, 1'b0};
        vecs[2] = '{12'd11,   16'h0011, 1'b0};
        vecs[3] = '{12'd10,   16'h0010, 1'b1};
        vecs[4] = '{12'd1005, 16'h1005, 1'b0};
        vecs[5] = '{12'd5,    16'h0005, 1'b1};
        @(negedge clk);
        check_reset_outputs("reset");
        exp_q.push_back(shown(16'h0060));
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        busy_n = 0;
        while (pulses < 1 && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
            busy_n += int'(busy);
        end
        check("first_latency", 32'(cyc), 14);
        check("busy_cycles", 32'(busy_n), 12);
        repeat (5) @(negedge clk);
        check("single_pulse", 32'(pulses), 1);
        for (int k = 0; k < 6; k++) begin
            counter = vecs[k].val;
            exp_q.push_back(shown(vecs[k].raw));
            wait_pulse(pulses + 1, cyc);
            hi = 0;
            repeat (2 * BHP + 2) begin
                @(negedge clk);
                hi += int'(warn_blink);
            end
            check("warn_seen", 32'(hi > 0), 32'(vecs[k].warn));
        end
        counter = 12'd9;
        exp_q.push_back(shown(16'h0009));
        wait_pulse(pulses + 1, cyc);
        prev = warn_blink;
        last_t = -1;
        trans = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (warn_blink !== prev) begin
                if (last_t >= 0) check("blink_interval", 32'(t - last_t), BHP);
                last_t = t;
                trans++;
            end
            prev = warn_blink;
        end
        check("blink_transitions", 32'(trans >= 4), 1);
        counter = 12'd60;
        exp_q.push_back(shown(16'h0060));
        exp_q.push_back(shown(16'h0059));
        repeat (6) @(negedge clk);
        check("busy_mid_shift", 32'(busy), 1);
        counter = 12'd59;
        wait_pulse(pulses + 1, cyc);
        wait_pulse(pulses + 1, c2);
        check("restart_gap", 32'(c2), 14);
        time_out = 1'b1;
        cyc = 0;
        while (!timeout_flash && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("flash_rise", 32'(cyc), 3);
        hi = 0;
        while (timeout_flash && hi < 40) begin
            @(negedge clk);
            hi++;
        end
        check("flash_len", 32'(hi), FC);
        time_out = 1'b0;
        counter = 12'd1234;
        repeat (5) @(negedge clk);
        check("busy_before_reset", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        @(negedge clk);
        exp_q.push_back(shown(16'h1234));
        rst = 1'b1;
        wait_pulse(pulses + 1, cyc);
        check("reconvert_latency", 32'(cyc), 14);
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
